// File: rtl/baccarat_pkg.sv
// Shared types and card-rule helpers for the baccarat round controller.
package baccarat_pkg;

  localparam int CARD_W = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_CHECK,
    S_P3,
    S_BANK,
    S_D3,
    S_RESULT
  } state_t;

  typedef struct packed {
    logic player;
    logic dealer;
    logic tie;
  } outcome_t;

  function automatic logic is_natural(input logic [CARD_W-1:0] score);
    return score >= 4'd8;
  endfunction

  // Banker third-card tableau, keyed on banker score and the player's third card.
  function automatic logic dealer_draws(input logic [CARD_W-1:0] dscore,
                                        input logic [CARD_W-1:0] pcard3);
    logic draw;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pcard3 != 4'd8);
      4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/baccarat_tally.sv
// Three saturating outcome counters; a clear in the same cycle as an increment wins.
module baccarat_tally
  import baccarat_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  outcome_t         inc,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player_wins <= '0;
      dealer_wins <= '0;
      ties        <= '0;
    end else if (clear) begin
      player_wins <= '0;
      dealer_wins <= '0;
      ties        <= '0;
    end else begin
      if (inc.player) player_wins <= sat_inc(player_wins);
      if (inc.dealer) dealer_wins <= sat_inc(dealer_wins);
      if (inc.tie)    ties        <= sat_inc(ties);
    end
  end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round sequencer: deals the cards, applies the third-card rules,
// registers the win lights and keeps saturating outcome tallies.
module baccarat_round_ctrl
  import baccarat_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit AUTO_START  = 1'b0,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              slow_clock,
  input  logic              resetb,
  input  logic              start,
  input  logic              clear_stats,
  input  logic [CARD_W-1:0] pscore,
  input  logic [CARD_W-1:0] dscore,
  input  logic [CARD_W-1:0] pcard3,
  output logic              load_pcard1,
  output logic              load_pcard2,
  output logic              load_pcard3,
  output logic              load_dcard1,
  output logic              load_dcard2,
  output logic              load_dcard3,
  output logic              player_win_light,
  output logic              dealer_win_light,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  player_wins,
  output logic [CNT_W-1:0]  dealer_wins,
  output logic [CNT_W-1:0]  ties
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t            state;
  state_t            nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              entering_result;
  outcome_t          outcome;
  outcome_t          inc;

  assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_P1;
      S_P1:    nxt = S_D1;
      S_D1:    nxt = S_P2;
      S_P2:    nxt = S_D2;
      S_D2:    nxt = S_CHECK;
      S_CHECK: begin
        if (is_natural(pscore) || is_natural(dscore)) nxt = S_RESULT;
        else if (pscore <= 4'd5)                      nxt = S_P3;
        else if (dscore <= 4'd5)                      nxt = S_D3;
        else                                          nxt = S_RESULT;
      end
      S_P3:    nxt = S_BANK;
      S_BANK:  nxt = dealer_draws(dscore, pcard3) ? S_D3 : S_RESULT;
      S_D3:    nxt = S_RESULT;
      S_RESULT: begin
        if (AUTO_START) begin
          if (hold_done) nxt = S_P1;
        end else if (start) begin
          nxt = S_P1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outcome is judged from the scores present on the edge that enters RESULT.
  assign entering_result = (nxt == S_RESULT) && (state != S_RESULT);
  assign outcome.player  = (pscore > dscore);
  assign outcome.dealer  = (dscore > pscore);
  assign outcome.tie     = (pscore == dscore);
  assign inc             = entering_result ? outcome : '0;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state            <= S_IDLE;
      hold_cnt         <= '0;
      load_pcard1      <= 1'b0;
      load_pcard2      <= 1'b0;
      load_pcard3      <= 1'b0;
      load_dcard1      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_dcard3      <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state       <= nxt;
      load_pcard1 <= (nxt == S_P1);
      load_dcard1 <= (nxt == S_D1);
      load_pcard2 <= (nxt == S_P2);
      load_dcard2 <= (nxt == S_D2);
      load_pcard3 <= (nxt == S_P3);
      load_dcard3 <= (nxt == S_D3);
      busy        <= (nxt != S_IDLE) && (nxt != S_RESULT);
      done        <= (nxt == S_RESULT);

      if (entering_result) begin
        player_win_light <= outcome.player | outcome.tie;
        dealer_win_light <= outcome.dealer | outcome.tie;
      end else if (nxt == S_P1) begin
        player_win_light <= 1'b0;
        dealer_win_light <= 1'b0;
      end

      // Counts the cycles already spent in RESULT; restarts on every entry.
      if (state != S_RESULT)  hold_cnt <= '0;
      else if (!hold_done)    hold_cnt <= hold_cnt + 1'b1;
    end
  end

  baccarat_tally #(
    .CNT_W(CNT_W)
  ) u_tally (
    .clk        (slow_clock),
    .rst_n      (resetb),
    .clear      (clear_stats),
    .inc        (inc),
    .player_wins(player_wins),
    .dealer_wins(dealer_wins),
    .ties       (ties)
  );

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Directed bench for baccarat_round_ctrl: a manual-start instance with 2-bit
// tallies and an auto-repeat instance share the clock, reset and score inputs.
module tb_baccarat_round_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetb, start, start_a, clear_stats;
  logic [3:0] pscore, dscore, pcard3;

  logic       lp1, lp2, lp3, ld1, ld2, ld3, pl, dl, busy, done;
  logic [1:0] pw, dw, tw;

  logic       lp1_a, lp2_a, lp3_a, ld1_a, ld2_a, ld3_a, pl_a, dl_a, busy_a, done_a;
  logic [7:0] pw_a, dw_a, tw_a;

  logic [5:0] strobes;
  assign strobes = {ld3, lp3, ld2, lp2, ld1, lp1};

  baccarat_round_ctrl #(.CNT_W(2), .AUTO_START(1'b0), .HOLD_CYCLES(4)) dut (
    .slow_clock(clk), .resetb(resetb), .start(start), .clear_stats(clear_stats),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
    .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
    .player_win_light(pl), .dealer_win_light(dl), .busy(busy), .done(done),
    .player_wins(pw), .dealer_wins(dw), .ties(tw)
  );

  baccarat_round_ctrl #(.CNT_W(8), .AUTO_START(1'b1), .HOLD_CYCLES(4)) dut_a (
    .slow_clock(clk), .resetb(resetb), .start(start_a), .clear_stats(clear_stats),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(lp1_a), .load_pcard2(lp2_a), .load_pcard3(lp3_a),
    .load_dcard1(ld1_a), .load_dcard2(ld2_a), .load_dcard3(ld3_a),
    .player_win_light(pl_a), .dealer_win_light(dl_a), .busy(busy_a), .done(done_a),
    .player_wins(pw_a), .dealer_wins(dw_a), .ties(tw_a)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] ds;
    logic [9:0] draw_mask;  // bit c set = banker draws when player's third card is c
  } tab_t;
  tab_t tab [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one round on the manual instance. Scores are held steady; dscore
  // switches to ds_fin while the banker's third card is being loaded.
  task automatic deal(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3,
                      input logic [3:0] ds_fin, output int edges, output logic [5:0] seen,
                      output logic round_ok, output logic [1:0] lights_p1);
    pscore = ps; dscore = ds; pcard3 = pc3; start = 1'b1;
    step();
    start = 1'b0; edges = 0; seen = '0; round_ok = 1'b1;
    lights_p1 = {pl, dl};
    while (!done && edges < 12) begin
      seen |= strobes;
      if ($countones(strobes) > 1 || !busy) round_ok = 1'b0;
      if (ld3) dscore = ds_fin;
      step();
      edges++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         e, n, hold;
    logic [5:0] s;
    logic       ok, exp_draw;
    logic [1:0] lp;

    tab[0] = '{4'd0, 10'b1111111111};
    tab[1] = '{4'd1, 10'b1111111111};
    tab[2] = '{4'd2, 10'b1111111111};
    tab[3] = '{4'd3, 10'b1011111111};
    tab[4] = '{4'd4, 10'b0011111100};
    tab[5] = '{4'd5, 10'b0011110000};
    tab[6] = '{4'd6, 10'b0011000000};
    tab[7] = '{4'd7, 10'b0000000000};

    resetb = 1'b0; start = 1'b0; start_a = 1'b0; clear_stats = 1'b0;
    pscore = '0; dscore = '0; pcard3 = '0;
    repeat (2) step();
    check("reset_outputs", {strobes, pl, dl, busy, done}, 0);
    check("reset_tallies", {pw, dw, tw}, 0);
    check("reset_auto_outputs", {ld3_a, lp3_a, ld2_a, lp2_a, ld1_a, lp1_a, busy_a, done_a}, 0);
    resetb = 1'b1;
    step(); step();
    check("idle_without_start", {busy, done}, 0);

    // Natural: player 9 vs banker 7
    deal(4'd9, 4'd7, 4'd0, 4'd7, e, s, ok, lp);
    check("nat_latency", e, 5);
    check("nat_no_third_cards", s[5:4], 0);
    check("nat_first_four_strobes", s[3:0], 4'hF);
    check("nat_lights", {pl, dl}, 2'b10);
    check("nat_player_wins", pw, 1);
    check("nat_round_ok", ok, 1);
    check("nat_result_busy", busy, 0);
    repeat (3) step();
    check("nat_result_holds", done, 1);

    // Player stands on 6, banker draws from 4 to 8
    deal(4'd6, 4'd4, 4'd5, 4'd8, e, s, ok, lp);
    check("stand_lights_cleared_p1", lp, 0);
    check("stand_latency", e, 6);
    check("stand_no_pcard3", s[4], 0);
    check("stand_dcard3", s[5], 1);
    check("stand_lights", {pl, dl}, 2'b01);
    check("stand_dealer_wins", dw, 1);
    check("stand_player_wins", pw, 1);

    // Banker tableau sweep with the player on 3
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 10; c++) begin
        deal(4'd3, tab[i].ds, 4'(c), tab[i].ds, e, s, ok, lp);
        exp_draw = tab[i].draw_mask[c];
        check($sformatf("tableau_d%0d_c%0d", tab[i].ds, c), {e[7:0], s[5], s[4], ok},
              {(exp_draw ? 8'd8 : 8'd7), exp_draw, 1'b1, 1'b1});
      end
    end
    deal(4'd3, 4'd3, 4'd8, 4'd3, e, s, ok, lp);
    check("spot_3_8_stands", s[5], 0);
    deal(4'd3, 4'd6, 4'd6, 4'd6, e, s, ok, lp);
    check("spot_6_6_draws", s[5], 1);

    // Ties with 2-bit tallies
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("clear_tallies", {pw, dw, tw}, 0);
    for (int r = 0; r < 4; r++) begin
      deal(4'd7, 4'd7, 4'd0, 4'd7, e, s, ok, lp);
      check($sformatf("tie_lights_r%0d", r), {pl, dl}, 2'b11);
      check($sformatf("tie_count_r%0d", r), tw, (r < 3) ? r + 1 : 3);
    end
    check("tie_others_zero", {pw, dw}, 0);

    // Asynchronous reset while in BANK
    pscore = 4'd3; dscore = 4'd4; pcard3 = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("bank_busy_before_reset", {busy, done, strobes}, {1'b1, 1'b0, 6'd0});
    resetb = 1'b0;
    #1;
    check("midround_reset_outputs", {strobes, pl, dl, busy, done}, 0);
    check("midround_reset_tallies", {pw, dw, tw}, 0);
    #2 resetb = 1'b1;
    step(); step();
    check("after_reset_idle", {busy, done}, 0);

    // clear_stats on the same edge as a tally increment
    deal(4'd7, 4'd7, 4'd0, 4'd7, e, s, ok, lp);
    check("pre_clear_ties", tw, 1);
    pscore = 4'd9; dscore = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("in_check_before_clear", {busy, done}, 2'b10);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("clear_wins_done", done, 1);
    check("clear_wins_tallies", {pw, dw, tw}, 0);
    check("clear_wins_lights", {pl, dl}, 2'b11);

    // Auto-repeat instance
    pscore = 4'd9; dscore = 4'd7; start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 12) begin step(); n++; end
    check("auto_latency", n, 5);
    check("auto_lights", {pl_a, dl_a}, 2'b10);
    hold = 0;
    while (done_a && hold < 20) begin hold++; step(); end
    check("auto_hold_cycles", hold, 4);
    check("auto_restart_pcard1", {lp1_a, busy_a}, 2'b11);
    check("auto_lights_cleared", {pl_a, dl_a}, 0);
    check("auto_player_wins_1", pw_a, 1);
    n = 0;
    while (!done_a && n < 12) begin
      start_a = (n == 2);
      step();
      n++;
    end
    start_a = 1'b0;
    check("auto_midround_start_ignored", n, 5);
    start_a = 1'b1;
    hold = 0;
    while (done_a && hold < 20) begin hold++; step(); end
    start_a = 1'b0;
    check("auto_start_ignored_in_result", hold, 4);
    check("auto_player_wins_2", pw_a, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
